// File: rtl/htp_pkg.sv
//----------------------------------------------------------------------------
// htp_pkg
//   Shared types, constants and helpers for the htp_mc tape reader.
//   Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

package htp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2
  } htp_state_e;

  localparam logic [7:0] BLANK_BYTE = 8'h00;

  // Parity bit over 7 data bits; odd=1 makes the 8-bit weight odd.
  function automatic logic htp_parity(input logic [6:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/htp_rr_arb.sv
//----------------------------------------------------------------------------
// htp_rr_arb
//   Round-robin pick: lowest-index request at or after the priority pointer.
//   Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module htp_rr_arb #(
  parameter int NCH  = 2,
  parameter int CH_W = 2
) (
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] prio,
  output logic [NCH-1:0]  gnt,
  output logic [CH_W-1:0] gnt_idx,
  output logic            gnt_vld
);

  logic [NCH-1:0] w_rot;
  int             w_sum;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    w_sum   = 0;
    // Rotating the request vector puts the priority channel at bit 0.
    w_rot   = NCH'({req, req} >> prio);
    for (int i = 0; i < NCH; i++) begin
      if (!gnt_vld && w_rot[i]) begin
        gnt_vld = 1'b1;
        w_sum   = int'(prio) + i;
        if (w_sum >= NCH) w_sum = w_sum - NCH;
      end
    end
    if (gnt_vld) begin
      gnt_idx = CH_W'(w_sum);
      gnt     = NCH'(1) << w_sum;
    end
  end

endmodule

`default_nettype wire

// File: rtl/htp_mc.sv
//----------------------------------------------------------------------------
// htp_mc
//   Multi-channel paper-tape reader sharing one synchronous tape ROM.
//   Optional parity insertion when HTP_PARITY_EN is defined.
//   Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module htp_mc
  import htp_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int TAPE_AW  = 12,
  parameter int TAPE_LEN = 4096,
  parameter int CH_W     = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NCH-1:0]          H_DREQ,
  output logic [NCH-1:0]          H_DRDY,
  output logic [8*NCH-1:0]        H_DIN,
  input  logic [NCH-1:0]          rewind,
  input  logic                    par_odd,
  output logic [NCH-1:0]          eot,
  output logic [CH_W+TAPE_AW-1:0] rom_addr,
  input  logic [7:0]              rom_q
);

  localparam logic [TAPE_AW-1:0] c_ptr_last = TAPE_AW'(TAPE_LEN - 1);
  localparam logic [CH_W-1:0]    c_last_ch  = CH_W'(NCH - 1);

  htp_state_e                r_state, w_state_nxt;
  logic [NCH-1:0]            r_dreq_q, r_pend, r_eot, r_drdy, r_gnt_oh;
  logic [TAPE_AW-1:0]        r_ptr [NCH];
  logic [7:0]                r_din [NCH];
  logic [CH_W-1:0]           r_gnt_idx, r_prio;
  logic                      r_kill;
  logic [CH_W+TAPE_AW-1:0]   r_rom_addr;

  logic [NCH-1:0]            w_gnt;
  logic [CH_W-1:0]           w_gnt_idx;
  logic                      w_gnt_vld, w_grant, w_load, w_gnt_eot, w_unused;
  logic [TAPE_AW-1:0]        w_gnt_ptr;
  logic [7:0]                w_rom_byte, w_blank_byte;

  htp_rr_arb #(.NCH(NCH), .CH_W(CH_W)) u_arb (
    .req     (r_pend),
    .prio    (r_prio),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .gnt_vld (w_gnt_vld)
  );

`ifdef HTP_PARITY_EN
  assign w_rom_byte   = {htp_parity(rom_q[6:0], par_odd), rom_q[6:0]};
  assign w_blank_byte = {htp_parity(BLANK_BYTE[6:0], par_odd), BLANK_BYTE[6:0]};
  assign w_unused     = rom_q[7];
`else
  assign w_rom_byte   = rom_q;
  assign w_blank_byte = BLANK_BYTE;
  assign w_unused     = par_odd;
`endif

  always_comb begin
    w_gnt_ptr = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w_gnt[c]) w_gnt_ptr = r_ptr[c];
    end
  end

  assign w_gnt_eot = |(r_eot & w_gnt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_load      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_gnt_vld) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        w_state_nxt = ST_IDLE;
        w_load      = (|(H_DREQ & r_gnt_oh)) && !(|(rewind & r_gnt_oh)) && !r_kill;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dreq_q   <= '0;
      r_pend     <= '0;
      r_eot      <= '0;
      r_drdy     <= '0;
      r_gnt_oh   <= '0;
      r_gnt_idx  <= '0;
      r_prio     <= '0;
      r_kill     <= 1'b0;
      r_rom_addr <= '0;
      for (int c = 0; c < NCH; c++) begin
        r_ptr[c] <= '0;
        r_din[c] <= '0;
      end
    end else begin
      r_dreq_q <= H_DREQ;

      // A rewind of the granted channel anywhere in its slot cancels the load.
      if (w_grant) begin
        r_gnt_oh  <= w_gnt;
        r_gnt_idx <= w_gnt_idx;
        r_kill    <= |(rewind & w_gnt);
        if (!w_gnt_eot) r_rom_addr <= {w_gnt_idx, w_gnt_ptr};
      end else if (r_state == ST_ADDR) begin
        r_kill <= r_kill | (|(rewind & r_gnt_oh));
      end

      if (r_state == ST_WAIT)
        r_prio <= (r_gnt_idx == c_last_ch) ? '0 : r_gnt_idx + 1'b1;

      for (int c = 0; c < NCH; c++) begin
        if (rewind[c]) begin
          r_ptr[c]  <= '0;
          r_eot[c]  <= 1'b0;
          r_pend[c] <= 1'b0;
          r_drdy[c] <= 1'b0;
        end else begin
          if (!H_DREQ[c]) begin
            r_pend[c] <= 1'b0;
            r_drdy[c] <= 1'b0;
          end else if (!r_dreq_q[c]) begin
            r_pend[c] <= 1'b1;
          end else if (w_grant && w_gnt[c]) begin
            r_pend[c] <= 1'b0;
          end
          if (w_load && r_gnt_oh[c]) begin
            r_drdy[c] <= 1'b1;
            r_din[c]  <= r_eot[c] ? w_blank_byte : w_rom_byte;
            if (!r_eot[c]) begin
              if (r_ptr[c] == c_ptr_last) r_eot[c] <= 1'b1;
              else                        r_ptr[c] <= r_ptr[c] + 1'b1;
            end
          end
        end
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_din
    assign H_DIN[8*c +: 8] = r_din[c];
  end

  assign H_DRDY   = r_drdy;
  assign eot      = r_eot;
  assign rom_addr = r_rom_addr;

endmodule

`default_nettype wire
